mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 15, giving the maximum number of BUSY cycles spent waiting for dmem_ack (range 1..15).
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
REQ-003 The block SHALL have these EX/MEM-side inputs:
- WB_MemtoReg_mem  in  2  writeback select
- WB_RegWrite_mem  in  1  register write enable
- MEM_MemWrite_mem  in  1  store
- MEM_MemRead_mem  in  1  load
- RegWriteAddr_mem  in  5  destination register
- PC_mem  in  32  instruction PC
- ALUResult_mem  in  32  effective address or ALU result
- MemWriteData_mem  in  32  store data
REQ-004 The block SHALL have these data-memory ports:
- dmem_req  out  1  request valid
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word address
- dmem_wdata  out  32  store data
- dmem_ack  in  1  one-cycle completion pulse
- dmem_rdata  in  32  load data, valid with dmem_ack
REQ-005 The block SHALL have these pipeline-side outputs:
- stall_mem  out  1  hold PC, IF/ID, ID/EX and EX/MEM
- WB_MemtoReg_wb  out  2  registered MEM/WB copy
- WB_RegWrite_wb  out  1  registered MEM/WB copy
- RegWriteAddr_wb  out  5  registered MEM/WB copy
- PC_wb  out  32  registered MEM/WB copy
- ALUResult_wb  out  32  registered MEM/WB copy
- MemReadData_wb  out  32  load data
- misalign_wb  out  1  misaligned-access flag
- bus_err_wb  out  1  timeout flag

Function
REQ-006 The FSM SHALL have states IDLE, BUSY and DONE.
REQ-007 An access SHALL be defined as acc = MEM_MemRead_mem | MEM_MemWrite_mem. An access is aligned when ALUResult_mem[1:0] == 0.
REQ-008 IDLE with an aligned access SHALL do the following:
- stall_mem = 1, combinational.
- At the next edge: go to BUSY; register dmem_addr = ALUResult_mem, dmem_wdata = MemWriteData_mem, dmem_we = MEM_MemWrite_mem; set dmem_req = 1; clear the timeout counter.
REQ-009 BUSY SHALL hold dmem_req = 1 and stall_mem = 1, keep dmem_addr, dmem_we and dmem_wdata stable, and increment the 4-bit counter every cycle.
REQ-010 In BUSY with dmem_ack = 1, the block SHALL capture dmem_rdata into an internal hold register, drop dmem_req at the edge, and go to DONE.
REQ-011 In BUSY, when the counter equals TIMEOUT-1 and dmem_ack = 0, the block SHALL set an internal error bit, drop dmem_req, and go to DONE. If ack and timeout fall in the same cycle, ack SHALL win.
REQ-012 DONE SHALL set stall_mem = 0, load MEM/WB from the held EX/MEM inputs at the edge, and return to IDLE.
- Loads: MemReadData_wb = hold register.
- On error: bus_err_wb = 1 and WB_RegWrite_wb = 0.
REQ-013 IDLE with a misaligned access SHALL not issue dmem_req and SHALL keep stall_mem = 0. MEM/WB SHALL load with WB_RegWrite_wb = 0 and misalign_wb = 1.
REQ-014 IDLE with no access SHALL keep stall_mem = 0 and load MEM/WB every cycle. MemReadData_wb, misalign_wb and bus_err_wb SHALL all be 0.
REQ-015 While stall_mem = 1 (IDLE-with-access and BUSY cycles), MEM/WB SHALL load a bubble: WB_RegWrite_wb = 0, WB_MemtoReg_wb = 0, flags 0. The other MEM/WB fields are don't-care; the bubble SHALL be driven as 0.
REQ-016 dmem_ack SHALL be ignored in IDLE and DONE.
REQ-017 Minimum access latency SHALL be 3 cycles from the instruction's arrival to its MEM/WB load: IDLE, then BUSY with immediate ack, then DONE.
REQ-018 misalign_wb and bus_err_wb SHALL each last exactly one cycle per faulting instruction.

Reset
REQ-019 With rst = 1 at an edge, the block SHALL set state IDLE, counter 0, hold and error registers 0, and all registered outputs 0: dmem_req, dmem_we, dmem_addr, dmem_wdata, and all *_wb. stall_mem SHALL be forced to 0 while rst = 1.
REQ-020 Reset during BUSY SHALL drop dmem_req at that edge. A late dmem_ack after reset SHALL be ignored.
REQ-021 rst SHALL take priority over every other event in the same cycle.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Load, ALUResult_mem = 0x100, ack on the first BUSY cycle with rdata = 0xDEADBEEF -> stall_mem high for 2 cycles; MemReadData_wb = 0xDEADBEEF and WB_RegWrite_wb = 1 one edge after DONE.
- Store, addr 0x204, data 0x12345678, ack after 4 BUSY cycles -> dmem_we = 1; addr and data stable all 4 cycles; stall_mem high for 5 cycles; no register write.
- Load with no ack, TIMEOUT = 15 -> dmem_req high exactly 15 cycles; bus_err_wb pulses 1 cycle; WB_RegWrite_wb = 0.
- Load at addr 0x102 -> no dmem_req; stall_mem stays 0; misalign_wb = 1 and WB_RegWrite_wb = 0 next cycle.
- rst asserted on the 2nd BUSY cycle, ack on the following cycle -> dmem_req = 0 after the reset edge; all *_wb = 0; ack ignored; FSM in IDLE.
- Back-to-back ALU instruction then load -> ALU result reaches MEM/WB with no stall; bubble(s) appear during the load stall; no duplicate register write.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: sequences loads/stores over a request/ack
// bus with timeout, stalls the front of the pipeline, and loads the MEM/WB register.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  WB_MemtoReg_mem,
    input  logic        WB_RegWrite_mem,
    input  logic        MEM_MemWrite_mem,
    input  logic        MEM_MemRead_mem,
    input  logic [4:0]  RegWriteAddr_mem,
    input  logic [31:0] PC_mem,
    input  logic [31:0] ALUResult_mem,
    input  logic [31:0] MemWriteData_mem,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall_mem,
    output logic [1:0]  WB_MemtoReg_wb,
    output logic        WB_RegWrite_wb,
    output logic [4:0]  RegWriteAddr_wb,
    output logic [31:0] PC_wb,
    output logic [31:0] ALUResult_wb,
    output logic [31:0] MemReadData_wb,
    output logic        misalign_wb,
    output logic        bus_err_wb
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Last counter value at which a missing ack is declared a bus error.
    localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hold_q, hold_d;
    logic        err_q, err_d;

    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;

    logic [1:0]  h_mtr_q, h_mtr_d;
    logic        h_rw_q, h_rw_d;
    logic [4:0]  h_rd_q, h_rd_d;
    logic [31:0] h_pc_q, h_pc_d;
    logic [31:0] h_alu_q, h_alu_d;
    logic        h_load_q, h_load_d;

    logic [1:0]  wb_mtr_q, wb_mtr_d;
    logic        wb_rw_q, wb_rw_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_pc_q, wb_pc_d;
    logic [31:0] wb_alu_q, wb_alu_d;
    logic [31:0] wb_rdata_q, wb_rdata_d;
    logic        wb_mis_q, wb_mis_d;
    logic        wb_err_q, wb_err_d;

    logic        acc_s;
    logic        aligned_s;
    logic        stall_s;

    assign acc_s     = MEM_MemRead_mem | MEM_MemWrite_mem;
    assign aligned_s = (ALUResult_mem[1:0] == 2'b00);

    // Next-state, bus request and MEM/WB load decisions.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hold_d     = hold_q;
        err_d      = err_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        h_mtr_d    = h_mtr_q;
        h_rw_d     = h_rw_q;
        h_rd_d     = h_rd_q;
        h_pc_d     = h_pc_q;
        h_alu_d    = h_alu_q;
        h_load_d   = h_load_q;
        wb_mtr_d   = 2'b00;
        wb_rw_d    = 1'b0;
        wb_rd_d    = 5'd0;
        wb_pc_d    = 32'h0000_0000;
        wb_alu_d   = 32'h0000_0000;
        wb_rdata_d = 32'h0000_0000;
        wb_mis_d   = 1'b0;
        wb_err_d   = 1'b0;
        stall_s    = 1'b0;

        case (state_q)
            IDLE: begin
                if (acc_s && aligned_s) begin
                    // Issue the access; MEM/WB takes a bubble while we wait.
                    stall_s  = 1'b1;
                    state_d  = BUSY;
                    req_d    = 1'b1;
                    we_d     = MEM_MemWrite_mem;
                    addr_d   = ALUResult_mem;
                    wdata_d  = MemWriteData_mem;
                    cnt_d    = 4'd0;
                    hold_d   = 32'h0000_0000;
                    err_d    = 1'b0;
                    h_mtr_d  = WB_MemtoReg_mem;
                    h_rw_d   = WB_RegWrite_mem;
                    h_rd_d   = RegWriteAddr_mem;
                    h_pc_d   = PC_mem;
                    h_alu_d  = ALUResult_mem;
                    h_load_d = MEM_MemRead_mem;
                end else begin
                    // Non-memory op passes straight through; a misaligned one is flagged and loses its write.
                    wb_mtr_d = WB_MemtoReg_mem;
                    wb_rw_d  = WB_RegWrite_mem & ~acc_s;
                    wb_rd_d  = RegWriteAddr_mem;
                    wb_pc_d  = PC_mem;
                    wb_alu_d = ALUResult_mem;
                    wb_mis_d = acc_s;
                end
            end
            BUSY: begin
                stall_s = 1'b1;
                cnt_d   = cnt_q + 4'd1;
                if (dmem_ack) begin
                    hold_d  = dmem_rdata;
                    req_d   = 1'b0;
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    req_d   = 1'b0;
                    state_d = DONE;
                end else begin
                    state_d = BUSY;
                end
            end
            DONE: begin
                wb_mtr_d   = h_mtr_q;
                wb_rw_d    = h_rw_q & ~err_q;
                wb_rd_d    = h_rd_q;
                wb_pc_d    = h_pc_q;
                wb_alu_d   = h_alu_q;
                wb_rdata_d = (h_load_q && !err_q) ? hold_q : 32'h0000_0000;
                wb_err_d   = err_q;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, bus and MEM/WB registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            hold_q     <= 32'h0000_0000;
            err_q      <= 1'b0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'h0000_0000;
            wdata_q    <= 32'h0000_0000;
            h_mtr_q    <= 2'b00;
            h_rw_q     <= 1'b0;
            h_rd_q     <= 5'd0;
            h_pc_q     <= 32'h0000_0000;
            h_alu_q    <= 32'h0000_0000;
            h_load_q   <= 1'b0;
            wb_mtr_q   <= 2'b00;
            wb_rw_q    <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_pc_q    <= 32'h0000_0000;
            wb_alu_q   <= 32'h0000_0000;
            wb_rdata_q <= 32'h0000_0000;
            wb_mis_q   <= 1'b0;
            wb_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hold_q     <= hold_d;
            err_q      <= err_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            h_mtr_q    <= h_mtr_d;
            h_rw_q     <= h_rw_d;
            h_rd_q     <= h_rd_d;
            h_pc_q     <= h_pc_d;
            h_alu_q    <= h_alu_d;
            h_load_q   <= h_load_d;
            wb_mtr_q   <= wb_mtr_d;
            wb_rw_q    <= wb_rw_d;
            wb_rd_q    <= wb_rd_d;
            wb_pc_q    <= wb_pc_d;
            wb_alu_q   <= wb_alu_d;
            wb_rdata_q <= wb_rdata_d;
            wb_mis_q   <= wb_mis_d;
            wb_err_q   <= wb_err_d;
        end
    end

    assign stall_mem       = stall_s & ~rst;
    assign dmem_req        = req_q;
    assign dmem_we         = we_q;
    assign dmem_addr       = addr_q;
    assign dmem_wdata      = wdata_q;
    assign WB_MemtoReg_wb  = wb_mtr_q;
    assign WB_RegWrite_wb  = wb_rw_q;
    assign RegWriteAddr_wb = wb_rd_q;
    assign PC_wb           = wb_pc_q;
    assign ALUResult_wb    = wb_alu_q;
    assign MemReadData_wb  = wb_rdata_q;
    assign misalign_wb     = wb_mis_q;
    assign bus_err_wb      = wb_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: instruction programs run against a
// transaction-level model (per-instruction stall/request/MEM-WB streams and a word memory).
module tb_mem_access_unit;

    localparam int TMO = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  WB_MemtoReg_mem;
    logic        WB_RegWrite_mem;
    logic        MEM_MemWrite_mem;
    logic        MEM_MemRead_mem;
    logic [4:0]  RegWriteAddr_mem;
    logic [31:0] PC_mem;
    logic [31:0] ALUResult_mem;
    logic [31:0] MemWriteData_mem;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        stall_mem;
    logic [1:0]  WB_MemtoReg_wb;
    logic        WB_RegWrite_wb;
    logic [4:0]  RegWriteAddr_wb;
    logic [31:0] PC_wb;
    logic [31:0] ALUResult_wb;
    logic [31:0] MemReadData_wb;
    logic        misalign_wb;
    logic        bus_err_wb;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT(TMO)) dut (
        .clk              (clk),
        .rst              (rst),
        .WB_MemtoReg_mem  (WB_MemtoReg_mem),
        .WB_RegWrite_mem  (WB_RegWrite_mem),
        .MEM_MemWrite_mem (MEM_MemWrite_mem),
        .MEM_MemRead_mem  (MEM_MemRead_mem),
        .RegWriteAddr_mem (RegWriteAddr_mem),
        .PC_mem           (PC_mem),
        .ALUResult_mem    (ALUResult_mem),
        .MemWriteData_mem (MemWriteData_mem),
        .dmem_req         (dmem_req),
        .dmem_we          (dmem_we),
        .dmem_addr        (dmem_addr),
        .dmem_wdata       (dmem_wdata),
        .dmem_ack         (dmem_ack),
        .dmem_rdata       (dmem_rdata),
        .stall_mem        (stall_mem),
        .WB_MemtoReg_wb   (WB_MemtoReg_wb),
        .WB_RegWrite_wb   (WB_RegWrite_wb),
        .RegWriteAddr_wb  (RegWriteAddr_wb),
        .PC_wb            (PC_wb),
        .ALUResult_wb     (ALUResult_wb),
        .MemReadData_wb   (MemReadData_wb),
        .misalign_wb      (misalign_wb),
        .bus_err_wb       (bus_err_wb)
    );

    // lat = BUSY cycle on which the responder acks; lat > TMO means it never acks.
    typedef struct packed {
        logic [1:0]  mtr;
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] wdata;
        logic        mr;
        logic        mw;
        logic [4:0]  lat;
    } instr_t;

    typedef struct packed {
        logic [1:0]  mtr;
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic        mis;
        logic        err;
    } wbrec_t;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] dev_mem [64];
    logic [31:0] ref_mem [64];
    instr_t      prog [$];
    instr_t      nop_i = '0;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic wbrec_t obs_wb();
        wbrec_t r;
        r.mtr   = WB_MemtoReg_wb;
        r.rw    = WB_RegWrite_wb;
        r.rd    = RegWriteAddr_wb;
        r.pc    = PC_wb;
        r.alu   = ALUResult_wb;
        r.rdata = MemReadData_wb;
        r.mis   = misalign_wb;
        r.err   = bus_err_wb;
        return r;
    endfunction

    task automatic drive(input instr_t i);
        WB_MemtoReg_mem  = i.mtr;
        WB_RegWrite_mem  = i.rw;
        RegWriteAddr_mem = i.rd;
        PC_mem           = i.pc;
        ALUResult_mem    = i.alu;
        MemWriteData_mem = i.wdata;
        MEM_MemRead_mem  = i.mr;
        MEM_MemWrite_mem = i.mw;
    endtask

    function automatic instr_t mk(input logic mr, input logic mw, input logic [31:0] alu,
                                  input logic [31:0] wdata, input logic [4:0] lat,
                                  input logic rw, input logic [1:0] mtr, input logic [31:0] pc);
        instr_t i;
        i = '0;
        i.mr = mr; i.mw = mw; i.alu = alu; i.wdata = wdata; i.lat = lat;
        i.rw = rw; i.mtr = mtr; i.pc = pc; i.rd = pc[6:2];
        return i;
    endfunction

    // Expected per-cycle streams are derived from the instruction list, then the
    // program is executed with a responder that acks on each instruction's chosen BUSY cycle.
    task automatic run_prog();
        wbrec_t exp_rec [$];
        bit     exp_stall [$];
        bit     exp_req [$];
        instr_t ins;
        instr_t cur;
        wbrec_t r;
        bit     acc;
        bit     to;
        int     nb;
        int     busy;
        int     idx;
        bit     st;
        logic [31:0] rnd;

        for (int i = 0; i < prog.size(); i++) begin
            ins = prog[i];
            acc = ins.mr | ins.mw;
            r = '{mtr: ins.mtr, rw: ins.rw, rd: ins.rd, pc: ins.pc, alu: ins.alu,
                  rdata: 32'h0, mis: 1'b0, err: 1'b0};
            if (acc && ins.alu[1:0] == 2'b00) begin
                to = (int'(ins.lat) > TMO);
                nb = to ? TMO : int'(ins.lat);
                exp_stall.push_back(1'b1); exp_req.push_back(1'b0); exp_rec.push_back('0);
                for (int b = 0; b < nb; b++) begin
                    exp_stall.push_back(1'b1); exp_req.push_back(1'b1); exp_rec.push_back('0);
                end
                if (to) begin
                    r.rw  = 1'b0;
                    r.err = 1'b1;
                end else if (ins.mr) begin
                    r.rdata = ref_mem[ins.alu[7:2]];
                end else begin
                    ref_mem[ins.alu[7:2]] = ins.wdata;
                end
            end else if (acc) begin
                r.rw  = 1'b0;
                r.mis = 1'b1;
            end
            exp_stall.push_back(1'b0); exp_req.push_back(1'b0); exp_rec.push_back(r);
        end

        @(posedge clk); #1;
        dmem_ack = 1'b0;
        cur = prog[0];
        drive(cur);
        idx  = 1;
        busy = 0;
        for (int k = 0; k < exp_stall.size(); k++) begin
            @(negedge clk);
            if (k > 0) check_eq($sformatf("wb[%0d]", k - 1), 128'(obs_wb()), 128'(exp_rec[k - 1]));
            check_eq($sformatf("stall[%0d]", k), 128'(stall_mem), 128'(exp_stall[k]));
            check_eq($sformatf("req[%0d]", k), 128'(dmem_req), 128'(exp_req[k]));
            if (dmem_req) begin
                busy++;
                check_eq($sformatf("addr[%0d]", k), 128'(dmem_addr), 128'(cur.alu));
                check_eq($sformatf("we[%0d]", k), 128'(dmem_we), 128'(cur.mw));
                if (cur.mw) check_eq($sformatf("wdata[%0d]", k), 128'(dmem_wdata), 128'(cur.wdata));
                if (busy == int'(cur.lat)) begin
                    dmem_ack = 1'b1;
                    if (cur.mr) dmem_rdata = dev_mem[cur.alu[7:2]];
                    else        dev_mem[cur.alu[7:2]] = cur.wdata;
                end else begin
                    dmem_ack = 1'b0;
                end
            end else begin
                // Stray acks outside BUSY must be ignored.
                busy = 0;
                rnd = $urandom;
                dmem_ack   = (rnd[1:0] == 2'b00);
                dmem_rdata = $urandom;
            end
            st = stall_mem;
            @(posedge clk); #1;
            dmem_ack = 1'b0;
            if (!st) begin
                cur = (idx < prog.size()) ? prog[idx] : nop_i;
                idx++;
                drive(cur);
            end
        end
        @(negedge clk);
        check_eq("wb_last", 128'(obs_wb()), 128'(exp_rec[exp_rec.size() - 1]));
        prog.delete();
    endtask

    initial begin
        instr_t      ri;
        logic [31:0] rnd;
        int          t;

        for (int i = 0; i < 64; i++) begin
            dev_mem[i] = 32'hC0DE_0000 | 32'(i);
            ref_mem[i] = 32'hC0DE_0000 | 32'(i);
        end
        dev_mem[0] = 32'hDEAD_BEEF;
        ref_mem[0] = 32'hDEAD_BEEF;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;

        // Reset with an aligned load presented: stall must stay low, everything cleared.
        rst = 1'b1;
        drive(mk(1'b1, 1'b0, 32'h100, 32'h0, 5'd1, 1'b1, 2'b01, 32'h40));
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        check_eq("rst_stall", 128'(stall_mem), 128'(0));
        check_eq("rst_req", 128'(dmem_req), 128'(0));
        check_eq("rst_bus", 128'({dmem_we, dmem_addr, dmem_wdata}), 128'(0));
        check_eq("rst_wb", 128'(obs_wb()), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        drive(nop_i);

        // Load with immediate ack.
        prog.push_back(mk(1'b1, 1'b0, 32'h100, 32'h0, 5'd1, 1'b1, 2'b01, 32'h1000));
        run_prog();
        // Store acked after 4 BUSY cycles.
        prog.push_back(mk(1'b0, 1'b1, 32'h204, 32'h1234_5678, 5'd4, 1'b0, 2'b00, 32'h1004));
        run_prog();
        // Load with no ack: timeout.
        prog.push_back(mk(1'b1, 1'b0, 32'h108, 32'h0, 5'd20, 1'b1, 2'b01, 32'h1008));
        run_prog();
        // Ack on the very last BUSY cycle must win over timeout.
        prog.push_back(mk(1'b1, 1'b0, 32'h10C, 32'h0, 5'(TMO), 1'b1, 2'b01, 32'h100C));
        run_prog();
        // Misaligned load.
        prog.push_back(mk(1'b1, 1'b0, 32'h102, 32'h0, 5'd1, 1'b1, 2'b01, 32'h1010));
        run_prog();
        // ALU op, load, ALU op back to back; load reads the word stored above.
        prog.push_back(mk(1'b0, 1'b0, 32'hCAFE_F00D, 32'h0, 5'd1, 1'b1, 2'b00, 32'h1014));
        prog.push_back(mk(1'b1, 1'b0, 32'h204, 32'h0, 5'd2, 1'b1, 2'b01, 32'h1018));
        prog.push_back(mk(1'b0, 1'b0, 32'h0000_0007, 32'h0, 5'd1, 1'b1, 2'b00, 32'h101C));
        run_prog();

        // Reset on the 2nd BUSY cycle, then a late ack.
        @(posedge clk); #1;
        drive(mk(1'b1, 1'b0, 32'h10, 32'h0, 5'd5, 1'b1, 2'b01, 32'h2000));
        @(negedge clk);
        check_eq("rb_idle_stall", 128'(stall_mem), 128'(1));
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("rb_busy1_req", 128'(dmem_req), 128'(1));
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check_eq("rb_rst_stall", 128'(stall_mem), 128'(0));
        @(posedge clk); #1;
        rst        = 1'b0;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hBAD0_BAD0;
        drive(nop_i);
        @(negedge clk);
        check_eq("rb_req", 128'(dmem_req), 128'(0));
        check_eq("rb_we", 128'(dmem_we), 128'(0));
        check_eq("rb_wb", 128'(obs_wb()), 128'(0));
        check_eq("rb_stall", 128'(stall_mem), 128'(0));
        // FSM must be back in IDLE: a fresh load behaves normally.
        prog.push_back(mk(1'b1, 1'b0, 32'h14, 32'h0, 5'd1, 1'b1, 2'b01, 32'h2004));
        run_prog();

        // Randomized mix of ALU ops, loads, stores, misaligned and slow/timeout accesses.
        for (int i = 0; i < 40; i++) begin
            ri  = '0;
            rnd = $urandom;
            t   = int'($urandom_range(0, 3));
            ri.mtr   = rnd[1:0];
            ri.rw    = rnd[2];
            ri.rd    = rnd[7:3];
            ri.pc    = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00} & 32'hFFFF_FFFC;
            ri.alu   = $urandom;
            ri.wdata = $urandom;
            ri.lat   = 5'($urandom_range(1, 5));
            if ($urandom_range(0, 7) == 0) ri.lat = 5'($urandom_range(14, 17));
            case (t)
                1: begin ri.mr = 1'b1; ri.alu[1:0] = 2'b00; ri.rw = 1'b1; ri.mtr = 2'b01; end
                2: begin ri.mw = 1'b1; ri.alu[1:0] = 2'b00; ri.rw = 1'b0; end
                3: begin
                    if (rnd[8]) ri.mr = 1'b1; else ri.mw = 1'b1;
                    ri.alu[1:0] = 2'($urandom_range(1, 3));
                end
                default: begin ri.mr = 1'b0; ri.mw = 1'b0; end
            endcase
            prog.push_back(ri);
        end
        run_prog();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
